// File: rtl/code_conv_sched_pkg.sv
// Shared definitions for the code converter scheduler.
//   - conversion select encodings
//   - code-range limits used to detect illegal BCD / Excess-3 inputs
//   - scheduler FSM state type
package code_conv_sched_pkg;

  localparam logic [1:0] SEL_BIN2GRAY = 2'b00;
  localparam logic [1:0] SEL_BCD2XS3  = 2'b01;
  localparam logic [1:0] SEL_GRAY2BIN = 2'b10;
  localparam logic [1:0] SEL_XS32BCD  = 2'b11;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/code_conv_core.sv
// Purely combinational 4-bit code converter.
// Ports:
//   code     in   4  input code
//   sel      in   2  conversion select (see SEL_* in the package)
//   code_out out  4  converted code, zero when the input is illegal
//   err      out  1  input code is illegal for the selected conversion
module code_conv_core
  import code_conv_sched_pkg::*;
(
  input  logic [3:0] code,
  input  logic [1:0] sel,
  output logic [3:0] code_out,
  output logic       err
);

  always_comb begin
    code_out = '0;
    err      = 1'b0;
    case (sel)
      SEL_BIN2GRAY: code_out = {code[3], code[3] ^ code[2], code[2] ^ code[1], code[1] ^ code[0]};
      SEL_BCD2XS3: begin
        if (code <= BCD_MAX) code_out = code + XS3_OFFSET;
        else                 err      = 1'b1;
      end
      // Each binary bit is the XOR of all Gray bits at or above it.
      SEL_GRAY2BIN: code_out = {code[3], ^code[3:2], ^code[3:1], ^code[3:0]};
      SEL_XS32BCD: begin
        if (code >= XS3_MIN && code <= XS3_MAX) code_out = code - XS3_OFFSET;
        else                                    err      = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/code_conv_sched.sv
// Round-robin scheduler sharing one code converter among NUM_REQ requesters.
// A winner is accepted in IDLE, its operand is converted in CONV, and the
// result is held on a valid/ready output in HOLD until taken downstream.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_code/req_sel   per-requester request (4-bit code, 2-bit select)
//   req_ready           one-hot accept strobe, only in IDLE
//   out_valid/out_ready result handshake
//   out_code/out_sel/out_id/out_err   registered result, select, requester, illegal flag
//   err_count           saturating count of delivered results flagged illegal
//   busy                FSM not idle
module code_conv_sched
  import code_conv_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_code,
  input  logic [2*NUM_REQ-1:0]   req_sel,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_code,
  output logic [1:0]             out_sel,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_err,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic                   busy
);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            grant;
  logic            xfer;

  logic [3:0]      op_code_p0;
  logic [1:0]      op_sel_p0;
  logic [ID_W-1:0] op_id_p0;

  logic [3:0]      conv_code;
  logic            conv_err;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt,
                                                   input logic               inc);
    if (inc && (cnt != '1)) return cnt + ERR_CNT_W'(1);
    return cnt;
  endfunction

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + ID_W'(1);
  endfunction

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign grant = (state == ST_IDLE) && found;
  assign xfer  = (state == ST_HOLD) && out_valid && out_ready;
  assign busy  = (state != ST_IDLE);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_CONV;
      ST_CONV: state_nxt = ST_HOLD;
      ST_HOLD: if (xfer) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage p0: operand capture on accept ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_code_p0 <= '0;
      op_sel_p0  <= '0;
      op_id_p0   <= '0;
      rr_ptr     <= '0;
    end else if (grant) begin
      op_code_p0 <= req_code[4*winner +: 4];
      op_sel_p0  <= req_sel[2*winner +: 2];
      op_id_p0   <= winner;
      rr_ptr     <= ptr_after(winner);
    end
  end

  code_conv_core u_core (
    .code     (op_code_p0),
    .sel      (op_sel_p0),
    .code_out (conv_code),
    .err      (conv_err)
  );

  // ---- stage p1: registered result and output handshake ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_sel   <= '0;
      out_id    <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else if (state == ST_CONV) begin
      out_valid <= 1'b1;
      out_code  <= conv_code;
      out_sel   <= op_sel_p0;
      out_id    <= op_id_p0;
      out_err   <= conv_err;
    end else if (xfer) begin
      out_valid <= 1'b0;
      err_count <= sat_inc(err_count, out_err);
    end
  end

endmodule

// File: tb/tb_code_conv_sched.sv
module tb_code_conv_sched;
  import code_conv_sched_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int ERR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_code;
  logic [2*NUM_REQ-1:0] req_sel;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_code;
  logic [1:0]           out_sel;
  logic [ID_W-1:0]      out_id;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy;

  code_conv_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_code(req_code), .req_sel(req_sel), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_sel(out_sel),
    .out_id(out_id), .out_err(out_err), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      code;
    logic [1:0]      sel;
    logic [ID_W-1:0] id;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   grants = 0;
  int   model_ptr = 0;
  int   model_err = 0;
  int   acc_cnt = 0;
  bit   idle_m = 1'b1;

  logic            prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
  logic [3:0]      prev_code = '0;
  logic [1:0]      prev_sel = '0;
  logic [ID_W-1:0] prev_id = '0;
  logic [3:0]      last_code = '0;
  logic            last_err = 1'b0;
  logic [ID_W-1:0] last_id = '0;

  logic [NUM_REQ-1:0] mon_rdy;
  int                 mon_w;
  exp_t               mon_e;
  logic [4:0]         mon_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference conversion, returns {err, code}.
  function automatic logic [4:0] ref_conv(input logic [3:0] c, input logic [1:0] s);
    logic [3:0] b;
    case (s)
      2'b00: return {1'b0, c ^ (c >> 1)};
      2'b01: return (c <= 4'd9) ? {1'b0, c + 4'd3} : 5'b10000;
      2'b10: begin
        b[3] = c[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ c[i];
        return {1'b0, b};
      end
      default: return (c >= 4'd3 && c <= 4'd12) ? {1'b0, c - 4'd3} : 5'b10000;
    endcase
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      acc_cnt++;
      mon_rdy = '0;
      mon_w   = -1;
      if (idle_m)
        for (int k = 0; k < NUM_REQ; k++)
          if (mon_w < 0 && req_valid[(model_ptr + k) % NUM_REQ]) mon_w = (model_ptr + k) % NUM_REQ;
      if (mon_w >= 0) mon_rdy[mon_w] = 1'b1;
      if (req_ready != '0 || mon_rdy != '0) chk("grant", 32'(req_ready), 32'(mon_rdy));
      if (mon_w >= 0) begin
        mon_r      = ref_conv(req_code[4*mon_w +: 4], req_sel[2*mon_w +: 2]);
        mon_e.code = mon_r[3:0];
        mon_e.err  = mon_r[4];
        mon_e.sel  = req_sel[2*mon_w +: 2];
        mon_e.id   = ID_W'(mon_w);
        sb.push_back(mon_e);
        gq.push_back(mon_w);
        grants++;
        model_ptr = (mon_w + 1) % NUM_REQ;
        idle_m    = 1'b0;
        acc_cnt   = 0;
      end
      if (out_valid && !prev_valid) chk("latency", 32'(acc_cnt), 32'd2);
      if (out_valid) chk("busy_hold", 32'(busy), 32'd1);
      if (out_valid && prev_valid && !prev_ready) begin
        chk("hold_code", 32'(out_code), 32'(prev_code));
        chk("hold_sel",  32'(out_sel),  32'(prev_sel));
        chk("hold_id",   32'(out_id),   32'(prev_id));
        chk("hold_err",  32'(out_err),  32'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("out_code", 32'(out_code), 32'(mon_e.code));
          chk("out_sel",  32'(out_sel),  32'(mon_e.sel));
          chk("out_id",   32'(out_id),   32'(mon_e.id));
          chk("out_err",  32'(out_err),  32'(mon_e.err));
          chk("err_count", 32'(err_count), 32'(model_err));
          if (mon_e.err && model_err < (1 << ERR_CNT_W) - 1) model_err++;
        end
        last_code = out_code;
        last_err  = out_err;
        last_id   = out_id;
        idle_m    = 1'b1;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_code  = out_code;
      prev_sel   = out_sel;
      prev_id    = out_id;
      prev_err   = out_err;
    end
  end

  task automatic wait_grants(input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (grants >= n) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) chk("grant_timeout", 32'(grants), 32'(n));
  endtask

  task automatic do_req(input int id, input logic [3:0] c, input logic [1:0] s);
    int g0;
    @(posedge clk); #1;
    req_code[4*id +: 4] = c;
    req_sel[2*id +: 2]  = s;
    req_valid[id]       = 1'b1;
    g0 = grants;
    wait_grants(g0 + 1);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (sb.size() == 0 && idle_m) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) chk("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_last(input string tag, input logic [3:0] c, input logic e, input int id);
    chk({tag, "_code"}, 32'(last_code), 32'(c));
    chk({tag, "_err"},  32'(last_err),  32'(e));
    chk({tag, "_id"},   32'(last_id),   32'(id));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_errc"},  32'(err_count), 32'd0);
    chk({tag, "_code"},  32'(out_code),  32'd0);
    chk({tag, "_id"},    32'(out_id),    32'd0);
    chk({tag, "_rdy"},   32'(req_ready), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    sb.delete();
    model_ptr = 0;
    model_err = 0;
    idle_m    = 1'b1;
  endtask

  int ord_a[5] = '{0, 1, 2, 3, 0};
  int ord_b[5] = '{1, 2, 3, 0, 2};
  int g;

  initial begin
    rst_n = 1'b1; req_valid = '0; req_code = '0; req_sel = '0; out_ready = 1'b1;
    #1 apply_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    rst_n = 1'b1;

    // Arbitration with all requesters held.
    for (int i = 0; i < NUM_REQ; i++) begin
      req_code[4*i +: 4] = 4'(i * 3 + 1);
      req_sel[2*i +: 2]  = 2'(i);
    end
    @(posedge clk); #1;
    req_valid = '1;
    wait_grants(5);
    req_valid = '0;
    wait_idle();
    for (int i = 0; i < 5; i++) chk("order_a", 32'(gq[i]), 32'(ord_a[i]));

    gq.delete();
    g = grants;
    req_valid = '1;
    wait_grants(g + 1);
    req_valid[1] = 1'b0;
    wait_grants(g + 5);
    req_valid = '0;
    wait_idle();
    for (int i = 0; i < 5; i++) chk("order_b", 32'(gq[i]), 32'(ord_b[i]));

    // Directed conversions.
    do_req(0, 4'b0110, SEL_BIN2GRAY); wait_idle(); check_last("b2g",   4'b0101, 1'b0, 0);
    do_req(1, 4'b0101, SEL_GRAY2BIN); wait_idle(); check_last("g2b",   4'b0110, 1'b0, 1);
    do_req(1, 4'd7,    SEL_BCD2XS3);  wait_idle(); check_last("bcd7",  4'b1010, 1'b0, 1);
    do_req(1, 4'b1100, SEL_XS32BCD);  wait_idle(); check_last("xs12",  4'b1001, 1'b0, 1);
    do_req(2, 4'd10,   SEL_BCD2XS3);  wait_idle(); check_last("bcd10", 4'b0000, 1'b1, 2);
    do_req(2, 4'd2,    SEL_XS32BCD);  wait_idle(); check_last("xs2",   4'b0000, 1'b1, 2);
    chk("err_count_2", 32'(err_count), 32'd2);
    do_req(3, 4'd9,    SEL_BCD2XS3);  wait_idle(); check_last("bcd9",  4'b1100, 1'b0, 3);
    do_req(3, 4'd3,    SEL_XS32BCD);  wait_idle(); check_last("xs3",   4'b0000, 1'b0, 3);
    do_req(0, 4'd13,   SEL_XS32BCD);  wait_idle(); check_last("xs13",  4'b0000, 1'b1, 0);
    chk("err_count_3", 32'(err_count), 32'd3);

    // Backpressure in HOLD with a competing request pending.
    out_ready = 1'b0;
    do_req(2, 4'b1011, SEL_BIN2GRAY);
    g = grants;
    req_valid[3] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_busy",  32'(busy),      32'd1);
    chk("bp_rdy",   32'(req_ready), 32'd0);
    chk("bp_code",  32'(out_code),  32'b1110);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_valid", 32'(out_valid), 32'd0);
    chk("bp_after_busy",  32'(busy),      32'd0);
    wait_grants(g + 1);
    req_valid[3] = 1'b0;
    wait_idle();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) do_req(i % 4, 4'(10 + i % 6), SEL_BCD2XS3);
    wait_idle();
    chk("err_sat", 32'(err_count), 32'd255);

    // Reset during CONV, then check the pointer restarted at 0.
    do_req(2, 4'd5, SEL_BIN2GRAY);
    apply_reset();
    #1 check_reset_state("rst_conv");
    @(posedge clk); #1;
    rst_n = 1'b1;
    gq.delete();
    g = grants;
    req_code[4*3 +: 4] = 4'd8; req_sel[2*3 +: 2] = SEL_GRAY2BIN;
    req_code[4*2 +: 4] = 4'd4; req_sel[2*2 +: 2] = SEL_BCD2XS3;
    req_valid[3] = 1'b1;
    req_valid[2] = 1'b1;
    wait_grants(g + 1);
    req_valid[2] = 1'b0;
    wait_grants(g + 2);
    req_valid = '0;
    wait_idle();
    chk("rst_order0", 32'(gq[0]), 32'd2);
    chk("rst_order1", 32'(gq[1]), 32'd3);

    // Reset during HOLD.
    out_ready = 1'b0;
    do_req(1, 4'd4, SEL_BCD2XS3);
    @(posedge clk); #1;
    chk("pre_rst_hold", 32'(out_valid), 32'd1);
    apply_reset();
    #1 check_reset_state("rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    do_req(2, 4'b1111, SEL_XS32BCD); wait_idle(); check_last("post_rst", 4'b0000, 1'b1, 2);
    chk("post_rst_errc", 32'(err_count), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/code_conv_sched.md
Name: code_conv_sched

Overview:
- Shared-resource scheduler for the 4-bit code converter datapath (binary->Gray, BCD->Excess-3, Gray->binary, Excess-3->BCD).
- Arbitrates NUM_REQ requesters round-robin onto one converter instance.
- Registers the operand and the result, and presents the result on a valid/ready output with requester ID and an error flag.
- Replaces don't-care outputs for illegal codes with a defined zero result plus an error flag, and keeps a saturating error count.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width (>= clog2(NUM_REQ))
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_code  in  4*NUM_REQ  per-requester 4-bit input code; requester i uses bits [4i+3:4i]
- req_sel  in  2*NUM_REQ  per-requester conversion select: 00 bin->gray, 01 bcd->xs3, 10 gray->bin, 11 xs3->bcd
- req_ready  out  NUM_REQ  one-hot accept strobe
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_code  out  4  converted code
- out_sel  out  2  select used
- out_id  out  ID_W  requester index served
- out_err  out  1  illegal input code for the selected conversion
- err_count  out  ERR_CNT_W  saturating count of delivered results with out_err=1
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rr_ptr=0; out_valid=0, out_code=0, out_sel=0, out_id=0, out_err=0, err_count=0, req_ready=0, busy=0. Reset mid-transaction discards the operand and result.
- FSM states: IDLE, CONV, HOLD.
- IDLE:
  - If any req_valid, winner = first set bit scanning from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally in this cycle only.
  - On the edge: latch code, sel and ID into operand regs; rr_ptr <= winner+1 (mod NUM_REQ); go to CONV.
  - If no req_valid, stay in IDLE.
- CONV:
  - Converter output computed from the operand regs and registered into out_code, out_sel, out_id, out_err.
  - out_valid <= 1; go to HOLD.
- HOLD:
  - out_* held stable while out_ready=0.
  - On out_valid && out_ready: out_valid <= 0; err_count += out_err (saturate at all-ones); go to IDLE.
- req_ready is 0 in CONV and HOLD; busy=1 in those states.
- Latency: accept at edge t -> out_valid high after edge t+1. Minimum 3 cycles per transaction (no overlap).
- Conversion rules:
  - bin->gray: {c3, c3^c2, c2^c1, c1^c0}
  - gray->bin: prefix XOR from the MSB
  - bcd->xs3: code+3, legal only for code<=9
  - xs3->bcd: code-3, legal only for 3<=code<=12
  - Illegal input: out_code=0, out_err=1. The Gray/binary conversions never set out_err.
- Request changes while not granted are ignored; a requester must hold req_valid until it sees req_ready.

Decomposition:
- Shared package holds:
  - select constants SEL_BIN2GRAY=2'b00, SEL_BCD2XS3=2'b01, SEL_GRAY2BIN=2'b10, SEL_XS32BCD=2'b11
  - XS3_OFFSET=4'd3, BCD_MAX=4'd9, XS3_MIN=4'd3, XS3_MAX=4'd12
  - FSM state typedef
- One sub-module: code_conv_core. Purely combinational converter taking code and sel, producing code_out and err.
- Arbiter and FSM stay in the top level.

Test Plan:
- Single requester 0: code=4'b0110, sel=00 -> out_code=4'b0101, out_err=0, out_id=0, out_valid 2 cycles after accept.
- Requester 1: sel=10, code=4'b0101 -> 4'b0110; sel=01, code=7 -> 4'b1010; sel=11, code=4'b1100 -> 4'b1001.
- Illegal codes: sel=01 with code=10, then sel=11 with code=2 -> out_code=0, out_err=1 both times; err_count=2. Force 300 errors with ERR_CNT_W=8 -> err_count sticks at 255.
- Arbitration: all 4 req_valid held continuously -> grant order 0,1,2,3,0. Drop req 1 after its first grant -> order continues 2,3,0,2.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_* stable, req_ready=0, busy=1; out_ready=1 -> one transfer, back to IDLE next cycle.
- Assert rst_n=0 asynchronously in CONV and in HOLD -> out_valid=0 immediately, err_count=0, rr_ptr=0; the next request from requester 2 is served normally.
